arb_buffer: RTL and testbench

Parametrised successor to the fixed four-input lane buffer. It arbitrates up to NUM_CH producer channels into one show-ahead FIFO of DEPTH words and presents the head word to a single consumer. It serves as the input buffer in front of each hardware subunit and as the output lane buffer after the output routers. Channel count, word width and depth are generics, and it adds backpressure-safe fairness and an occupancy output.

---
 rtl/arb_buffer.sv | 160 ++++++++++++++++
 tb/tb_arb_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_buffer.sv
// -----------------------------------------------------------------------------
// arb_buffer
//
// Arbitrates NUM_CH producer channels into a single show-ahead FIFO of DEPTH
// words and presents the registered head word to one consumer.
//
// Configuration macro:
//   ARB_BUFFER_FIXED_PRIO_EN  defined   -> fixed priority, lowest offering
//                                          channel wins, no rr_ptr
//                             undefined -> round-robin arbitration (default)
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high reset
//   in_data   in   NUM_CH words, channel i at [i*DATA_W +: DATA_W];
//                  bit DATA_W-1 of each word is its valid/offer flag
//   ready     out  one-hot (or zero) accept strobe per channel
//   in_ready  in   consumer accepts out_data this cycle
//   out_data  out  registered FIFO head, all zeros when empty
//   count     out  current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module arb_buffer #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 35,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          ready,
    input  logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] chan_word [NUM_CH];
    logic [NUM_CH-1:0] offer;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign chan_word[i] = in_data[i*DATA_W +: DATA_W];
        assign offer[i]     = in_data[i*DATA_W + DATA_W - 1];
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [CH_W-1:0]   grant_idx;
    logic              grant_vld;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_word;

`ifdef ARB_BUFFER_FIXED_PRIO_EN
    // Descending scan so the lowest-index offering channel is written last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (offer[CH_W'(i)]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(i);
            end
        end
    end
`else
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

    // Cyclic scan starting at rr_ptr; iterating from the farthest offset down
    // lets the nearest offering channel overwrite the others.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (offer[CH_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
`endif

    // Full blocks pushes regardless of a same-cycle pop, so ready never
    // depends on in_ready. Reset gating keeps ready low while state clears.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign push      = grant_vld && !full && !reset;
    assign ready     = push ? (NUM_CH'(1) << grant_idx) : '0;
    assign push_word = chan_word[grant_idx];
    assign pop       = out_data_q[DATA_W-1] && in_ready;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        // Next head: nothing when empty; the word being written when the new
        // read pointer lands on the write slot (push into empty, or pop of
        // the last word with a simultaneous push); otherwise stored data.
        if (count_d == '0)
            out_data_d = '0;
        else if (push && (rd_ptr_d == wr_ptr_q))
            out_data_d = push_word;
        else
            out_data_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

    // NOTE: storage is not reset; count and pointers define which entries are
    // live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign out_data = out_data_q;
    assign count    = count_q;

endmodule

// File: tb/tb_arb_buffer.sv
// -----------------------------------------------------------------------------
// tb_arb_buffer: directed self-checking bench for arb_buffer (4 ch, 35 b, 8 deep).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_arb_buffer;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 35;
    localparam int DEPTH  = 8;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]          ready;
    logic                       in_ready;
    logic [DATA_W-1:0]          out_data;
    logic [$clog2(DEPTH+1)-1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .ready    (ready),
        .in_ready (in_ready),
        .out_data (out_data),
        .count    (count)
    );

    function automatic logic [DATA_W-1:0] w(input int v);
        return {1'b1, 34'(v)};
    endfunction

    task automatic set_ch(input int i, input logic [DATA_W-1:0] v);
        in_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_data  = '0;
        in_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_ready = 1'b0;
        in_data  = '0;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, w(32'h20 + i));
        #1;
        checks++;
        if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_pre got=%b exp=0000", ready); end
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (ready !== 4'b0000) begin errors++; $display("FAIL reset_ready c%0d got=%b exp=0000", c, ready); end
            checks++;
            if (out_data !== '0) begin errors++; $display("FAIL reset_out c%0d got=%h exp=0", c, out_data); end
            checks++;
            if (count !== 4'd0) begin errors++; $display("FAIL reset_count c%0d got=%0d exp=0", c, count); end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ready !== 4'b0001) begin errors++; $display("FAIL post_reset_ready got=%b exp=0001", ready); end
        checks++;
        if (count !== 4'd0 || out_data !== '0) begin
            errors++; $display("FAIL post_reset_state count=%0d out=%h exp 0/0", count, out_data);
        end
        tick();
        in_data = '0;
    endtask

    task automatic test_single_latency();
        do_reset();
        in_ready = 1'b1;
        set_ch(2, 35'h4_0000_00AA);
        #1;
        checks++;
        if (ready !== 4'b0100) begin errors++; $display("FAIL lat_ready got=%b exp=0100", ready); end
        checks++;
        if (count !== 4'd0 || out_data !== '0) begin errors++; $display("FAIL lat_c0 count=%0d out=%h exp 0/0", count, out_data); end
        tick();
        in_data = '0;
        #1;
        checks++;
        if (out_data !== 35'h4_0000_00AA) begin errors++; $display("FAIL lat_out got=%h exp=4000000aa", out_data); end
        checks++;
        if (count !== 4'd1) begin errors++; $display("FAIL lat_count1 got=%0d exp=1", count); end
        checks++;
        if (ready !== 4'b0000) begin errors++; $display("FAIL lat_ready_idle got=%b exp=0000", ready); end
        tick();
        checks++;
        if (out_data !== '0 || count !== 4'd0) begin errors++; $display("FAIL lat_drain out=%h count=%0d exp 0/0", out_data, count); end
    endtask

    task automatic test_round_robin();
        int prev;
        do_reset();
        in_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) set_ch(i, w(32'h30 + i));
        prev = 0;
        for (int c = 0; c < 9; c++) begin
            int g;
`ifdef ARB_BUFFER_FIXED_PRIO_EN
            g = 0;
`else
            g = c % NUM_CH;
`endif
            #1;
            checks++;
            if (ready !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant c%0d got=%b exp=%b", c, ready, 4'(1 << g)); end
            if (c > 0) begin
                checks++;
                if (out_data !== w(32'h30 + prev)) begin errors++; $display("FAIL rr_out c%0d got=%h exp=%h", c, out_data, w(32'h30 + prev)); end
                checks++;
                if (count !== 4'd1) begin errors++; $display("FAIL rr_count c%0d got=%0d exp=1", c, count); end
            end
            prev = g;
            tick();
        end
        in_data = '0;
    endtask

    task automatic test_rr_skip();
        do_reset();
        in_ready = 1'b1;
        set_ch(1, w(32'h41));
        set_ch(3, w(32'h43));
        for (int c = 0; c < 6; c++) begin
            logic [3:0] exp;
`ifdef ARB_BUFFER_FIXED_PRIO_EN
            exp = 4'b0010;
`else
            exp = (c % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            #1;
            checks++;
            if (ready !== exp) begin errors++; $display("FAIL rr_skip c%0d got=%b exp=%b", c, ready, exp); end
            tick();
        end
        in_data = '0;
    endtask

    task automatic test_full();
        do_reset();
        in_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            set_ch(1, w(k));
            #1;
            checks++;
            if (ready !== 4'b0010 || count !== 4'(k - 1)) begin
                errors++; $display("FAIL full_fill k%0d ready=%b count=%0d exp 0010/%0d", k, ready, count, k - 1);
            end
            tick();
        end
        set_ch(1, w(9));
        #1;
        checks++;
        if (ready !== 4'b0000) begin errors++; $display("FAIL full_ready got=%b exp=0000", ready); end
        checks++;
        if (count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count); end
        in_ready = 1'b1;
        #1;
        checks++;
        if (ready !== 4'b0000 || out_data !== w(1)) begin
            errors++; $display("FAIL full_popcycle ready=%b out=%h exp 0000/%h", ready, out_data, w(1));
        end
        tick();
        checks++;
        if (ready !== 4'b0010 || count !== 4'd7 || out_data !== w(2)) begin
            errors++; $display("FAIL full_reaccept ready=%b count=%0d out=%h exp 0010/7/%h", ready, count, out_data, w(2));
        end
        tick();
        in_data = '0;
        for (int j = 3; j <= 9; j++) begin
            #1;
            checks++;
            if (out_data !== w(j) || count !== 4'(10 - j)) begin
                errors++; $display("FAIL full_drain j%0d out=%h count=%0d exp %h/%0d", j, out_data, count, w(j), 10 - j);
            end
            tick();
        end
        checks++;
        if (out_data !== '0 || count !== 4'd0) begin errors++; $display("FAIL full_empty out=%h count=%0d", out_data, count); end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] q[$];
        int s;
        do_reset();
        s = 32'h100;
        in_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_ch(3, w(s));
            q.push_back(w(s));
            s++;
            tick();
        end
        in_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            set_ch(3, w(s));
            #1;
            checks++;
            if (count !== 4'd3 || ready !== 4'b1000) begin
                errors++; $display("FAIL wrap_state c%0d count=%0d ready=%b exp 3/1000", c, count, ready);
            end
            checks++;
            if (out_data !== q[0]) begin errors++; $display("FAIL wrap_order c%0d got=%h exp=%h", c, out_data, q[0]); end
            q.push_back(w(s));
            void'(q.pop_front());
            s++;
            tick();
        end
        in_data = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_ch(0, w(32'h200 + k));
            tick();
        end
        in_data = '0;
        #1;
        checks++;
        if (count !== 4'd5) begin errors++; $display("FAIL mid_count_pre got=%0d exp=5", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || out_data !== '0) begin errors++; $display("FAIL mid_reset count=%0d out=%h exp 0/0", count, out_data); end
        in_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_data !== '0 || count !== 4'd0) begin errors++; $display("FAIL mid_stale c%0d out=%h count=%0d", c, out_data, count); end
        end
        set_ch(0, w(32'h777));
        tick();
        in_data = '0;
        #1;
        checks++;
        if (out_data !== w(32'h777) || count !== 4'd1) begin
            errors++; $display("FAIL mid_new out=%h count=%0d exp %h/1", out_data, count, w(32'h777));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_round_robin();
        test_rr_skip();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
